// File: rtl/uart_rx_cmd_framer.sv
// Assembles UART byte strobes into header+payload command frames and presents
// them on a valid/ready interface, flagging bad length, timeout and overrun.
module uart_rx_cmd_framer #(
  parameter int NBITS          = 8,
  parameter int MAX_PAYLOAD    = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_rx_done,
  input  logic [NBITS-1:0]             i_rx_data,
  output logic                         o_cmd_valid,
  input  logic                         i_cmd_ready,
  output logic [3:0]                   o_opcode,
  output logic [3:0]                   o_length,
  output logic [MAX_PAYLOAD*NBITS-1:0] o_payload,
  output logic                         o_err,
  output logic [1:0]                   o_err_code,
  output logic                         o_busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    MAX_LEN  = 4'(MAX_PAYLOAD);

  typedef enum logic [1:0] {IDLE, PAYLOAD, HOLD} state_t;

  state_t                       state, state_nx;
  logic [3:0]                   opcode_nx, length_nx, idx, idx_nx;
  logic [MAX_PAYLOAD*NBITS-1:0] payload_nx;
  logic [CW-1:0]                cnt, cnt_nx;
  logic                         err_nx;
  logic [1:0]                   code_nx;
  logic                         take_header;

  always_comb begin
    state_nx    = state;
    opcode_nx   = o_opcode;
    length_nx   = o_length;
    payload_nx  = o_payload;
    idx_nx      = idx;
    cnt_nx      = cnt;
    err_nx      = 1'b0;
    code_nx     = o_err_code;
    take_header = 1'b0;

    case (state)
      IDLE: take_header = i_rx_done;
      PAYLOAD: begin
        if (i_rx_done) begin
          for (int unsigned k = 0; k < MAX_PAYLOAD; k++) begin
            if (4'(k) == idx) payload_nx[k*NBITS +: NBITS] = i_rx_data;
          end
          idx_nx = idx + 4'd1;
          cnt_nx = '0;
          if (idx + 4'd1 == o_length) state_nx = HOLD;
        end else if (cnt == CNT_LAST) begin
          err_nx   = 1'b1;
          code_nx  = 2'b10;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HOLD: begin
        // A byte arriving with ready completes the handshake and is the next header.
        if (i_cmd_ready) begin
          state_nx    = IDLE;
          take_header = i_rx_done;
        end else if (i_rx_done) begin
          err_nx  = 1'b1;
          code_nx = 2'b11;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (take_header) begin
      opcode_nx  = i_rx_data[7:4];
      length_nx  = i_rx_data[3:0];
      payload_nx = '0;
      idx_nx     = '0;
      if (i_rx_data[3:0] > MAX_LEN) begin
        err_nx   = 1'b1;
        code_nx  = 2'b01;
        state_nx = IDLE;
      end else if (i_rx_data[3:0] == 4'd0) begin
        state_nx = HOLD;
      end else begin
        cnt_nx   = '0;
        state_nx = PAYLOAD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      o_opcode    <= '0;
      o_length    <= '0;
      o_payload   <= '0;
      idx         <= '0;
      cnt         <= '0;
      o_err       <= 1'b0;
      o_err_code  <= '0;
      o_cmd_valid <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_nx;
      o_opcode    <= opcode_nx;
      o_length    <= length_nx;
      o_payload   <= payload_nx;
      idx         <= idx_nx;
      cnt         <= cnt_nx;
      o_err       <= err_nx;
      o_err_code  <= code_nx;
      o_cmd_valid <= (state_nx == HOLD);
      o_busy      <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_framer.sv
// Directed-vector bench for uart_rx_cmd_framer with a short timeout window.
module tb_uart_rx_cmd_framer;

  localparam int NBITS = 8;
  localparam int MAXP  = 4;
  localparam int TO    = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  rx_done = 1'b0;
  logic [NBITS-1:0]      rx_data = '0;
  logic                  cmd_valid;
  logic                  cmd_ready = 1'b0;
  logic [3:0]            opcode, length;
  logic [MAXP*NBITS-1:0] payload;
  logic                  err;
  logic [1:0]            err_code;
  logic                  busy;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_cmd_framer #(.NBITS(NBITS), .MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_opcode(opcode),
    .o_length(length), .o_payload(payload), .o_err(err), .o_err_code(err_code),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    tick();
    rx_done = 1'b0;
    rx_data = '0;
  endtask

  logic stable;

  initial begin
    tick();
    tick();
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    check("rst_hdr", {24'd0, opcode, length}, 32'h0);
    check("rst_payload", payload, 32'h0);
    rst = 1'b0;
    tick();

    // reset mid-payload after 2 of 3 bytes
    send(8'h43);
    send(8'h01);
    send(8'h02);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hdr", {24'd0, opcode, length}, 32'h0);
    check("arst_payload", payload, 32'h0);
    check("arst_valid", 32'(cmd_valid), 32'd0);
    #2 rst = 1'b0;
    tick();
    send(8'h20);
    check("len0_valid", 32'(cmd_valid), 32'd1);
    send(8'hAA);
    check("len0_ovr_err", 32'(err), 32'd1);
    check("len0_ovr_code", 32'(err_code), 32'd3);
    send(8'hBB);
    check("len0_hdr", {24'd0, opcode, length}, 32'h20);
    check("len0_payload", payload, 32'h0);
    check("len0_valid2", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    tick();
    check("len0_acc_valid", 32'(cmd_valid), 32'd0);
    check("len0_acc_busy", 32'(busy), 32'd0);

    // 3-byte frame with ready held high
    send(8'h53);
    check("f3_busy", 32'(busy), 32'd1);
    check("f3_novalid", 32'(cmd_valid), 32'd0);
    send(8'h11);
    send(8'h22);
    check("f3_novalid2", 32'(cmd_valid), 32'd0);
    send(8'h33);
    check("f3_valid", 32'(cmd_valid), 32'd1);
    check("f3_hdr", {24'd0, opcode, length}, 32'h53);
    check("f3_payload", payload, 32'h00332211);
    tick();
    check("f3_drop", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0;

    // hold frame while ready low
    send(8'h70);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!cmd_valid || opcode != 4'h7 || length != 4'h0 || payload != '0) stable = 1'b0;
      tick();
    end
    check("hold_stable", 32'(stable), 32'd1);
    check("hold_valid", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    tick();
    check("hold_release", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0;

    // length above MAX_PAYLOAD
    send(8'h15);
    check("badlen_err", 32'(err), 32'd1);
    check("badlen_code", 32'(err_code), 32'd1);
    check("badlen_busy", 32'(busy), 32'd0);
    check("badlen_valid", 32'(cmd_valid), 32'd0);
    tick();
    check("badlen_pulse", 32'(err), 32'd0);
    check("badlen_code_hold", 32'(err_code), 32'd1);

    // timeout: counter reaches TO-1 after TO-1 idle cycles, fires on the next
    send(8'h92);
    send(8'h44);
    for (int i = 0; i < TO - 1; i++) tick();
    check("to_pre_err", 32'(err), 32'd0);
    check("to_pre_busy", 32'(busy), 32'd1);
    tick();
    check("to_err", 32'(err), 32'd1);
    check("to_code", 32'(err_code), 32'd2);
    check("to_busy", 32'(busy), 32'd0);
    check("to_valid", 32'(cmd_valid), 32'd0);

    // byte on the last counter value wins
    send(8'h92);
    send(8'h44);
    for (int i = 0; i < TO - 1; i++) tick();
    send(8'h55);
    check("tow_err", 32'(err), 32'd0);
    check("tow_valid", 32'(cmd_valid), 32'd1);
    check("tow_payload", payload, 32'h00005544);

    // overrun in HOLD, then back-to-back frame on accept
    send(8'hFF);
    check("ovr_err", 32'(err), 32'd1);
    check("ovr_code", 32'(err_code), 32'd3);
    check("ovr_hdr", {24'd0, opcode, length}, 32'h92);
    check("ovr_payload", payload, 32'h00005544);
    check("ovr_valid", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    send(8'h31);
    cmd_ready = 1'b0;
    check("b2b_valid", 32'(cmd_valid), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_err", 32'(err), 32'd0);
    check("b2b_hdr", {24'd0, opcode, length}, 32'h31);
    check("b2b_payload", payload, 32'h0);
    send(8'h66);
    check("b2b_valid2", 32'(cmd_valid), 32'd1);
    check("b2b_payload2", payload, 32'h00000066);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
